board_cmd_if: RTL and testbench

Board-level command front-end between the FPGA pins and `CPU_top`. It debounces the push-buttons, captures a switch-encoded command into an address, data and opcode triple, and issues it to the CPU with a valid/ready handshake. For read commands it waits for read data and latches the result. It drives an N-digit multiplexed hex seven-segment display with paging across the 32-bit result.

---
 rtl/board_cmd_if.sv | 207 ++++++++++++++++++++
 tb/tb_board_cmd_if.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_cmd_if.sv
// Board command front-end: debounced buttons, switch command capture, valid/ready issue,
// read-data capture and a paged multiplexed hex display. Define BOARD_IF_TIMEOUT_EN for read timeout.
module board_cmd_if #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 6,
   parameter int NDIG       = 4,
   parameter int DEB_CYCLES = 1000000,
   parameter int SCAN_DIV   = 100000,
   parameter int TIMEOUT    = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDR_W+DATA_W+1:0] sw,
   input  logic                     btn_go,
   input  logic                     btn_page,
   output logic                     cmd_valid,
   input  logic                     cmd_ready,
   output logic [1:0]               cmd,
   output logic [31:0]              addr_out,
   output logic [31:0]              data_out,
   input  logic [31:0]              rdata_in,
   input  logic                     rdata_valid,
   output logic                     busy,
   output logic [NDIG-1:0]          an,
   output logic [6:0]               seg,
   output logic                     dp,
   output logic [1:0]               state
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_WAIT_RD = 2'd2;

   localparam int DCW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int SCW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DIGW  = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int NPAGE = 32 / (4 * NDIG);

   // Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready;
   // cmd, addr_out and data_out stay constant while cmd_valid is high.

   logic [1:0]     raw;
   logic [1:0]     sync0;
   logic [1:0]     sync1;
   logic [1:0]     level;
   logic [1:0]     press;
   logic [DCW-1:0] deb_cnt [2];
   logic           go_press;
   logic           page_press;

   assign raw        = {btn_page, btn_go};
   assign go_press   = press[0];
   assign page_press = press[1];

   // Index 0 is the go button, index 1 the page button.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync0 <= '0;
         sync1 <= '0;
         level <= '0;
         press <= '0;
         for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
      end else begin
         sync0 <= raw;
         sync1 <= sync0;
         for (int i = 0; i < 2; i++) begin
            press[i] <= 1'b0;
            if (sync1[i] == level[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DCW'(DEB_CYCLES - 1)) begin
               level[i]   <= sync1[i];
               deb_cnt[i] <= '0;
               press[i]   <= sync1[i];
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   logic [31:0] disp_reg;
   logic        err;

`ifdef BOARD_IF_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TW-1:0] tcnt;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cmd_valid <= 1'b0;
         cmd       <= 2'b00;
         addr_out  <= '0;
         data_out  <= '0;
         disp_reg  <= '0;
`ifdef BOARD_IF_TIMEOUT_EN
         err       <= 1'b0;
         tcnt      <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (go_press) begin
                  addr_out  <= 32'(sw[ADDR_W-1:0]);
                  data_out  <= 32'(sw[ADDR_W+DATA_W-1:ADDR_W]);
                  cmd       <= sw[ADDR_W+DATA_W+1:ADDR_W+DATA_W];
                  cmd_valid <= 1'b1;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= (cmd == 2'b10) ? S_WAIT_RD : S_IDLE;
`ifdef BOARD_IF_TIMEOUT_EN
                  tcnt      <= '0;
`endif
               end
            end
            S_WAIT_RD: begin
               if (rdata_valid) begin
                  disp_reg <= rdata_in;
`ifdef BOARD_IF_TIMEOUT_EN
                  err      <= 1'b0;
`endif
                  state    <= S_IDLE;
               end
`ifdef BOARD_IF_TIMEOUT_EN
               else if (tcnt == TW'(TIMEOUT - 1)) begin
                  disp_reg <= 32'hDEADDEAD;
                  err      <= 1'b1;
                  state    <= S_IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state != S_IDLE);

   logic [SCW-1:0]  scan_cnt;
   logic [DIGW-1:0] digit;
   logic [2:0]      page;
   logic [2:0]      nib_idx;
   logic [3:0]      nibble;

   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt <= '0;
         digit    <= '0;
         page     <= '0;
      end else begin
         if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            digit    <= (digit == DIGW'(NDIG - 1)) ? '0 : digit + 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         if (page_press) page <= (page == 3'(NPAGE - 1)) ? 3'd0 : page + 3'd1;
      end
   end

   assign nib_idx = 3'((int'(page) * NDIG) + int'(digit));
   assign nibble  = disp_reg[{nib_idx, 2'b00} +: 4];

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   // Display outputs are registered, so they trail the digit index by one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         an  <= '1;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= ~(NDIG'(1) << digit);
         seg <= ~hex7(nibble);
         dp  <= ~(err && (digit == '0));
      end
   end

endmodule

// File: tb/tb_board_cmd_if.sv
// Bench for board_cmd_if: vector table, hand sequences and randomized commands against a
// behavioural model of command fields and display contents.
module tb_board_cmd_if;

   localparam int NDIG  = 4;
   localparam int DEB   = 4;
   localparam int SDIV  = 2;
   localparam int TMO   = 8;
   localparam int NPAGE = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] sw;
   logic        btn_go, btn_page, cmd_ready, rdata_valid;
   logic [31:0] rdata_in;
   logic        cmd_valid, busy, dp;
   logic [1:0]  cmd, state;
   logic [31:0] addr_out, data_out;
   logic [3:0]  an;
   logic [6:0]  seg;

   always #5 clk = ~clk;

   board_cmd_if #(.ADDR_W(8), .DATA_W(6), .NDIG(NDIG), .DEB_CYCLES(DEB), .SCAN_DIV(SDIV),
                  .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .sw(sw), .btn_go(btn_go), .btn_page(btn_page),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .addr_out(addr_out),
      .data_out(data_out), .rdata_in(rdata_in), .rdata_valid(rdata_valid), .busy(busy),
      .an(an), .seg(seg), .dp(dp), .state(state)
   );

   int          checks = 0;
   int          failures = 0;
   logic [31:0] disp_m;
   int          page_m;
   bit          err_m;
   logic [6:0]  hex_tbl [16];

   typedef struct {
      logic [15:0] sw;
      int          rdy;
      logic [31:0] rd;
      int          rdd;
      logic [31:0] e_addr;
      logic [31:0] e_data;
      logic [1:0]  e_cmd;
      bit          e_rd;
   } vec_t;
   vec_t vecs [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic press_page();
      btn_page = 1'b1;
      repeat (DEB + 6) tick();
      btn_page = 1'b0;
      repeat (DEB + 6) tick();
      page_m = (page_m + 1) % NPAGE;
   endtask

   task automatic check_display();
      logic [3:0] seen;
      logic [6:0] exp_seg;
      logic       exp_dp;
      int         k;
      int         nib;
      seen = '0;
      repeat (2 * NDIG * SDIV + 2) begin
         tick();
         if (an !== 4'hF) begin
            check("an_onehot", $countones(~an), 1);
            k = -1;
            for (int j = 0; j < NDIG; j++) if (an[j] == 1'b0) k = j;
            if (k >= 0) begin
               nib     = int'((disp_m >> ((page_m * NDIG + k) * 4)) % 16);
               exp_seg = ~hex_tbl[nib];
               exp_dp  = (err_m && k == 0) ? 1'b0 : 1'b1;
               check("seg_digit", seg, exp_seg);
               check("dp_digit", dp, exp_dp);
               seen[k] = 1'b1;
            end
         end
      end
      check("digits_seen", seen, 4'hF);
   endtask

   task automatic do_cmd(input logic [15:0] sw_v, input int rdy_dly, input logic [31:0] rd_v,
                         input int rd_dly, input bit go_in_wait, input logic [31:0] e_addr,
                         input logic [31:0] e_data, input logic [1:0] e_cmd, input bit e_rd);
      int n;
      int count;
      bit extra;
      sw        = sw_v;
      cmd_ready = (rdy_dly == 0);
      btn_go    = 1'b1;
      n = 0;
      while (!cmd_valid && n < 40) begin
         tick();
         n++;
      end
      check("go_to_valid_bounded", cmd_valid, 1);
      btn_go = 1'b0;
      sw     = 16'($urandom);
      count  = 1;
      if (cmd_valid) begin
         forever begin
            check("cmd_field", cmd, e_cmd);
            check("addr_field", addr_out, e_addr);
            check("data_field", data_out, e_data);
            check("busy_issue", busy, 1);
            if (count == rdy_dly + 1) cmd_ready = 1'b1;
            tick();
            if (!cmd_valid || count >= rdy_dly + 20) break;
            count++;
         end
         check("valid_cycles", count, rdy_dly + 1);
      end
      cmd_ready = 1'b0;
      if (e_rd) begin
         check("busy_after_rd_accept", busy, 1);
         if (rd_dly < 0) begin
            n = 0;
            while (busy && n < TMO + 10) begin
               tick();
               n++;
            end
            check("timeout_cycles", n, TMO);
            disp_m = 32'hDEADDEAD;
            err_m  = 1'b1;
         end else begin
            if (go_in_wait) begin
               extra  = 1'b0;
               sw     = 16'h80EE;
               btn_go = 1'b1;
               repeat (DEB + 6) begin
                  tick();
                  if (cmd_valid) extra = 1'b1;
               end
               btn_go = 1'b0;
               repeat (DEB + 6) begin
                  tick();
                  if (cmd_valid) extra = 1'b1;
               end
               check("no_issue_while_busy", extra, 0);
               check("addr_held_while_busy", addr_out, e_addr);
            end
            repeat (rd_dly) begin
               check("busy_in_wait", busy, 1);
               tick();
            end
            rdata_in    = rd_v;
            rdata_valid = 1'b1;
            tick();
            rdata_valid = 1'b0;
            rdata_in    = $urandom;
            check("busy_after_rdata", busy, 0);
            disp_m = rd_v;
            err_m  = 1'b0;
         end
      end else begin
         check("busy_after_write", busy, 0);
      end
      extra = 1'b0;
      repeat (DEB + 6) begin
         tick();
         if (cmd_valid) extra = 1'b1;
      end
      check("no_reissue", extra, 0);
   endtask

   initial begin
      hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      vecs[0] = '{16'h6A15, 3, 32'h0,        0, 32'h15, 32'h2A, 2'b01, 1'b0};
      vecs[1] = '{16'h8080, 0, 32'h1234ABCD, 5, 32'h80, 32'h00, 2'b10, 1'b1};
      vecs[2] = '{16'hFFFF, 1, 32'h0,        0, 32'hFF, 32'h3F, 2'b11, 1'b0};
      vecs[3] = '{16'h0100, 2, 32'h0,        0, 32'h00, 32'h01, 2'b00, 1'b0};

      reset = 1'b1; sw = '0; btn_go = 1'b0; btn_page = 1'b0; cmd_ready = 1'b0;
      rdata_valid = 1'b0; rdata_in = '0;
      disp_m = '0; page_m = 0; err_m = 1'b0;
      repeat (3) tick();
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_cmd", cmd, 0);
      check("rst_addr", addr_out, 0);
      check("rst_data", data_out, 0);
      check("rst_busy", busy, 0);
      check("rst_an", an, 4'hF);
      check("rst_seg", seg, 7'h7F);
      check("rst_dp", dp, 1);
      check("rst_state_idle", state, 2'd0);
      reset = 1'b0;
      tick();
      check("first_digit_after_reset", an, 4'hE);

      // Bouncing go button: 2-cycle pulses never reach the debounce threshold.
      begin
         bit rose = 1'b0;
         repeat (5) begin
            btn_go = 1'b1; tick(); if (cmd_valid) rose = 1'b1;
            tick(); if (cmd_valid) rose = 1'b1;
            btn_go = 1'b0; tick(); if (cmd_valid) rose = 1'b1;
            tick(); if (cmd_valid) rose = 1'b1;
         end
         repeat (12) begin
            tick();
            if (cmd_valid) rose = 1'b1;
         end
         check("bounce_rejected", rose, 0);
      end

      // Spurious read data while idle must not touch the display.
      rdata_in = 32'hFFFF_FFFF; rdata_valid = 1'b1;
      tick();
      rdata_valid = 1'b0;
      check("rdata_idle_busy", busy, 0);
      check_display();

      for (int i = 0; i < 4; i++)
         do_cmd(vecs[i].sw, vecs[i].rdy, vecs[i].rd, vecs[i].rdd, 1'b0,
                vecs[i].e_addr, vecs[i].e_data, vecs[i].e_cmd, vecs[i].e_rd);

      check_display();
      press_page();
      check_display();
      press_page();
      check_display();

`ifdef BOARD_IF_TIMEOUT_EN
      do_cmd(16'h8042, 1, 32'h0, -1, 1'b0, 32'h42, 32'h00, 2'b10, 1'b1);
      check_display();
      do_cmd(16'h8001, 0, 32'hCAFE0123, 2, 1'b0, 32'h01, 32'h00, 2'b10, 1'b1);
      check_display();
`else
      do_cmd(16'h8033, 2, 32'h89ABCDEF, 3, 1'b1, 32'h33, 32'h00, 2'b10, 1'b1);
      check_display();
`endif

      repeat (8) begin
         logic [15:0] sv;
         logic [31:0] rv;
         sv = 16'($urandom);
         rv = $urandom;
         do_cmd(sv, $urandom_range(0, 4), rv, $urandom_range(0, 6), 1'b0,
                32'(sv % 256), 32'((sv / 256) % 64), 2'(sv / 16384), (sv / 16384) == 2);
         if ($urandom_range(0, 2) == 0) press_page();
         check_display();
      end

      // Reset while a command is being offered drops it at once.
      sw = 16'h4155; cmd_ready = 1'b0; btn_go = 1'b1;
      begin
         int n = 0;
         while (!cmd_valid && n < 40) begin
            tick();
            n++;
         end
      end
      check("reset_test_valid_up", cmd_valid, 1);
      reset = 1'b1;
      tick();
      check("reset_issue_valid", cmd_valid, 0);
      check("reset_issue_an", an, 4'hF);
      check("reset_issue_seg", seg, 7'h7F);
      check("reset_issue_busy", busy, 0);
      check("reset_issue_state", state, 2'd0);
      check("reset_issue_addr", addr_out, 0);
      btn_go = 1'b0;
      reset  = 1'b0;
      disp_m = '0; page_m = 0; err_m = 1'b0;
      tick();
      check("reset_issue_first_digit", an, 4'hE);
      repeat (DEB + 6) tick();
      check("reset_issue_no_valid", cmd_valid, 0);
      check_display();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
